// File: rtl/pacman_pkg.sv
// Shared pacman map geometry, tile codes and coin-tracker state encoding.
package pacman_pkg;

   localparam int MAP_W = 48;
   localparam int MAP_H = 27;
   localparam int TILES = MAP_W * MAP_H;

   localparam logic [3:0] TILE_BG   = 4'd0;
   localparam logic [3:0] TILE_WALL = 4'd1;
   localparam logic [3:0] TILE_COIN = 4'd2;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_CLEAR
   } state_t;

endpackage

// File: rtl/coin_bitmap_ram.sv
// One bit per tile: port A reads/writes for map load and eating, port B is the pixel read port.
// Both ports read synchronously; a read that collides with a write returns the old bit.
module coin_bitmap_ram
   import pacman_pkg::*;
#(
   parameter int DEPTH = TILES
) (
   input  logic        clk_pix,
   input  logic [10:0] addr_a,
   input  logic        we_a,
   input  logic        wd_a,
   output logic        q_a,
   input  logic [10:0] addr_b,
   output logic        q_b
);

   logic mem [0:DEPTH-1];

   always_ff @(posedge clk_pix) begin
      if (we_a) mem[addr_a] <= wd_a;
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
   end

endmodule

// File: rtl/coin_tracker.sv
// Coin bookkeeping: loads the coin bitmap from the tile ROM, eats coins under pacman,
// keeps score and remaining-coin count, and serves per-pixel coin lookups.
module coin_tracker #(
   parameter int MAP_W  = pacman_pkg::MAP_W,
   parameter int MAP_H  = pacman_pkg::MAP_H,
   parameter int POINTS = 10
) (
   input  logic        clk_pix,
   input  logic        rstn,
   input  logic        restart,
   output logic [10:0] rom_addr,
   input  logic [3:0]  rom_code,
   input  logic [10:0] pac_tile_addr,
   input  logic [10:0] pix_tile_addr,
   output logic        pix_coin,
   output logic [10:0] coins_left,
   output logic [15:0] score,
   output logic        eat_pulse,
   output logic        init_done,
   output logic        level_clear
);
   import pacman_pkg::*;

   localparam int          N_TILES   = MAP_W * MAP_H;
   localparam logic [10:0] TILE_END  = 11'(N_TILES);
   localparam logic [10:0] LAST_TILE = 11'(N_TILES - 1);

   function automatic logic [15:0] sat_add_points(input logic [15:0] acc);
      logic [16:0] sum;
      sum = {1'b0, acc} + 17'(POINTS);
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   state_t      state, state_nxt;
   logic [10:0] scan;
   logic        scan_done;
   logic        ld_vld_p0;
   logic [10:0] ld_addr_p0;
   logic [10:0] pac_addr_p0;
   logic        pac_rd_p0;
   logic        pix_ok_p0;
   logic        load_coin, load_last, hit;
   logic [10:0] ram_addr_a;
   logic        ram_we_a, ram_wd_a, ram_q_a, ram_q_b;

   coin_bitmap_ram #(.DEPTH(N_TILES)) u_bitmap (
      .clk_pix (clk_pix),
      .addr_a  (ram_addr_a),
      .we_a    (ram_we_a),
      .wd_a    (ram_wd_a),
      .q_a     (ram_q_a),
      .addr_b  (pix_tile_addr),
      .q_b     (ram_q_b)
   );

   assign rom_addr    = scan;
   assign pix_coin    = ram_q_b & pix_ok_p0;
   assign init_done   = (state != ST_INIT);
   assign level_clear = (state == ST_CLEAR);

   // Port A: ROM load writes in INIT; in RUN it reads the tile under pacman, except on
   // an eat cycle where it clears the registered tile (pac_rd_p0 then marks q_a stale).
   always_comb begin
      load_coin  = ld_vld_p0 && (rom_code == TILE_COIN);
      load_last  = ld_vld_p0 && (ld_addr_p0 == LAST_TILE);
      hit        = (state == ST_RUN) && pac_rd_p0 && ram_q_a && (pac_addr_p0 < TILE_END);
      ram_addr_a = pac_tile_addr;
      ram_we_a   = 1'b0;
      ram_wd_a   = 1'b0;
      if (ld_vld_p0) begin
         ram_addr_a = ld_addr_p0;
         ram_we_a   = !restart;
         ram_wd_a   = (rom_code == TILE_COIN);
      end else if (hit) begin
         ram_addr_a = pac_addr_p0;
         ram_we_a   = !restart;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT:  if (load_last) state_nxt = (coins_left == '0 && !load_coin) ? ST_CLEAR : ST_RUN;
         ST_RUN:   if (hit && coins_left == 11'd1) state_nxt = ST_CLEAR;
         default:  state_nxt = state;
      endcase
      if (restart) state_nxt = ST_INIT;
   end

   always_ff @(posedge clk_pix or negedge rstn) begin
      if (!rstn) state <= ST_INIT;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk_pix or negedge rstn) begin
      if (!rstn) begin
         scan       <= '0;
         scan_done  <= 1'b0;
         ld_vld_p0  <= 1'b0;
         pac_rd_p0  <= 1'b0;
         pix_ok_p0  <= 1'b0;
         coins_left <= '0;
         score      <= '0;
         eat_pulse  <= 1'b0;
      end else if (restart) begin
         scan       <= '0;
         scan_done  <= 1'b0;
         ld_vld_p0  <= 1'b0;
         pac_rd_p0  <= 1'b0;
         pix_ok_p0  <= 1'b0;
         coins_left <= '0;
         score      <= '0;
         eat_pulse  <= 1'b0;
      end else begin
         if (state == ST_INIT) begin
            if (scan != LAST_TILE) scan <= scan + 11'd1;
            scan_done <= (scan == LAST_TILE);
         end
         ld_vld_p0 <= (state == ST_INIT) && !scan_done;
         pac_rd_p0 <= (state == ST_RUN) && !hit;
         pix_ok_p0 <= (state != ST_INIT) && (pix_tile_addr < TILE_END);
         eat_pulse <= hit;
         if (load_coin)
            coins_left <= coins_left + 11'd1;
         else if (hit && coins_left != '0)
            coins_left <= coins_left - 11'd1;
         if (hit) score <= sat_add_points(score);
      end
   end

   // p0 stage: ROM load address and pacman tile, qualified by ld_vld_p0 / pac_rd_p0
   always_ff @(posedge clk_pix) begin
      ld_addr_p0  <= scan;
      pac_addr_p0 <= pac_tile_addr;
   end

endmodule

// File: doc/coin_tracker.md
COIN_TRACKER -- requirements
Module: coin_tracker

Interface
REQ-001 SHALL have parameter MAP_W, default 48, map width in tiles.
REQ-002 SHALL have parameter MAP_H, default 27, map height in tiles.
REQ-003 SHALL have parameter POINTS, default 10, score added per coin eaten.
REQ-004 SHALL have port clk_pix  in  1  pixel clock, the only clock; all logic rising-edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port restart  in  1  one-cycle pulse; reload coins and clear score.
REQ-007 SHALL have port rom_addr  out  11  address to the tile-map ROM init port.
REQ-008 SHALL have port rom_code  in  4  ROM data; valid 1 cycle after rom_addr.
REQ-009 SHALL have port pac_tile_addr  in  11  tile address under the pacman centre.
REQ-010 SHALL have port pix_tile_addr  in  11  tile address of the current pixel.
REQ-011 SHALL have port pix_coin  out  1  coin present at pix_tile_addr; 1-cycle latency.
REQ-012 SHALL have port coins_left  out  11  count of remaining coins.
REQ-013 SHALL have port score  out  16  accumulated score, binary.
REQ-014 SHALL have port eat_pulse  out  1  one-cycle pulse per coin eaten.
REQ-015 SHALL have port init_done  out  1  high in RUN and CLEAR states.
REQ-016 SHALL have port level_clear  out  1  high in CLEAR state.

Function
REQ-017 SHALL implement states INIT, RUN and CLEAR, with TILES = MAP_W*MAP_H (1296).
REQ-018 SHALL leave reset in INIT with scan counter 0 and drive rom_addr equal to the scan counter.
REQ-019 SHALL, in INIT, advance the scan counter by 1 per cycle up to TILES-1 and write bitmap[scan-1] = (rom_code==2) one cycle later.
REQ-020 SHALL, in INIT, increment coins_left on every written 1, so coins_left equals the ROM coin count at INIT exit.
REQ-021 SHALL go from INIT to RUN on the cycle after the write of tile TILES-1, so INIT lasts TILES+1 cycles.
REQ-022 SHALL, in RUN, register pac_tile_addr once; if the registered address < TILES and its bit is 1, then next cycle: clear the bit, decrement coins_left, add POINTS to score, and pulse eat_pulse.
REQ-023 SHALL saturate score at 65535 and never let coins_left go below 0.
REQ-024 SHALL eat a tile only once, including while pacman stays on it.
REQ-025 SHALL go from RUN to CLEAR on the cycle coins_left becomes 0, and from INIT directly to CLEAR if the map has no coins.
REQ-026 SHALL, in CLEAR, hold score and coins_left, ignore eating, and stay there until restart or reset.
REQ-027 SHALL drive pix_coin as the registered bitmap[pix_tile_addr], forced to 0 in INIT and for addresses >= TILES.
REQ-028 SHALL, when the pixel read and the eat write hit the same address in one cycle, return the old value (read-before-write).
REQ-029 SHALL, on restart in any state (including mid-INIT), zero the scan counter, coins_left, score and eat_pulse, and enter INIT next cycle.
REQ-030 SHALL give restart priority over a simultaneous eat.

Reset
REQ-031 SHALL, while rstn is low, hold rom_addr=0, pix_coin=0, coins_left=0, score=0, eat_pulse=0, init_done=0, level_clear=0, state=INIT.
REQ-032 SHALL leave bitmap contents undefined at reset; INIT overwrites every bit before any read is exposed.

Structure
REQ-033 SHALL place MAP_W, MAP_H, TILES and the tile code constants (BG=0, WALL=1, COIN=2) in shared package pacman_pkg.
REQ-034 SHALL place the state enum in pacman_pkg.
REQ-035 SHALL store the bitmap in one sub-module, coin_bitmap_ram: 1296x1, one read/write port for init and eat, one read-only port for pixels, synchronous read.

Verification
REQ-036 SHALL cover init: ROM with codes 2 at addresses 0, 5, 1295 and others 0 -> init_done rises 1297 cycles after reset release; coins_left=3.
REQ-037 SHALL cover eat: after init, pac_tile_addr=5 held for 10 cycles -> exactly one eat_pulse, coins_left=2, score=10, pix_coin at address 5 reads 0.
REQ-038 SHALL cover clear: eat addresses 0 and 1295 after REQ-037 -> level_clear=1 with score=30; further pac moves do not change score.
REQ-039 SHALL cover a same-cycle conflict: pix_tile_addr=pac_tile_addr=0 on the eat cycle -> pix_coin=1 that cycle, 0 on the next read.
REQ-040 SHALL cover restart mid-INIT: restart at scan 600 -> coins_left=0 and score=0 next cycle, and the full 1297-cycle INIT repeats with coins_left=3.
REQ-041 SHALL cover out-of-range and saturation: pac_tile_addr=2000 -> no eat; score preloaded near 65535 with POINTS=10 -> score stays at 65535.
